// File: rtl/writeback_regfile_pkg.sv
// Shared register-file constants and MIPS register aliases for the writeback stage and hazard logic.
package writeback_regfile_pkg;

    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;

    localparam logic [REG_IDX_W-1:0] REG_AT = 5'd1;
    localparam logic [REG_IDX_W-1:0] REG_V0 = 5'd2;
    localparam logic [REG_IDX_W-1:0] REG_V1 = 5'd3;
    localparam logic [REG_IDX_W-1:0] REG_A0 = 5'd4;
    localparam logic [REG_IDX_W-1:0] REG_GP = 5'd28;
    localparam logic [REG_IDX_W-1:0] REG_SP = 5'd29;
    localparam logic [REG_IDX_W-1:0] REG_FP = 5'd30;
    localparam logic [REG_IDX_W-1:0] REG_RA = 5'd31;

    function automatic logic is_zero_reg(input logic [REG_IDX_W-1:0] idx);
        return idx == ZERO_REG;
    endfunction

endpackage

// File: rtl/writeback_regfile_regfile_2r1w.sv
// 32-entry, two-read one-write register file with async clear, hardwired r0
// and same-cycle write-through bypass on both read ports.
module regfile_2r1w
    import writeback_regfile_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_we,
    input  logic [REG_IDX_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]     i_wdata,
    input  logic [REG_IDX_W-1:0] i_raddr1,
    input  logic [REG_IDX_W-1:0] i_raddr2,
    output logic [WIDTH-1:0]     o_rdata1,
    output logic [WIDTH-1:0]     o_rdata2
);

    logic [WIDTH-1:0]     r_regs [NUM_REGS];
    logic                 w_we_eff;
    logic [REG_IDX_W-1:0] w_raddr [2];
    logic [WIDTH-1:0]     w_rdata [2];

    // i_we gates the address compare, so an X index is harmless while idle.
    assign w_we_eff = i_we && !is_zero_reg(i_waddr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we_eff) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign w_raddr[0] = i_raddr1;
    assign w_raddr[1] = i_raddr2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rport
            assign w_rdata[gi] = is_zero_reg(w_raddr[gi])                ? '0      :
                                 (i_we && (i_waddr == w_raddr[gi]))      ? i_wdata :
                                                                           r_regs[w_raddr[gi]];
        end
    endgenerate

    assign o_rdata1 = w_rdata[0];
    assign o_rdata2 = w_rdata[1];

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: selects the W-stage result, commits it to the register file,
// and keeps a retire counter plus last-write capture for debug.
module writeback_regfile
    import writeback_regfile_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RegWriteW,
    input  logic                 MemtoRegW,
    input  logic [WIDTH-1:0]     ALUOutW,
    input  logic [WIDTH-1:0]     ReadDataW,
    input  logic [REG_IDX_W-1:0] WriteRegW,
    input  logic [REG_IDX_W-1:0] A1,
    input  logic [REG_IDX_W-1:0] A2,
    output logic [WIDTH-1:0]     RD1,
    output logic [WIDTH-1:0]     RD2,
    output logic [WIDTH-1:0]     ResultW,
    output logic [CNT_W-1:0]     RetireCount,
    output logic [REG_IDX_W-1:0] LastWriteReg,
    output logic [WIDTH-1:0]     LastWriteData
);

    logic [WIDTH-1:0]     w_result;
    logic                 w_commit;
    logic [CNT_W-1:0]     r_retire_count;
    logic [REG_IDX_W-1:0] r_last_reg;
    logic [WIDTH-1:0]     r_last_data;

    assign w_result = MemtoRegW ? ReadDataW : ALUOutW;
    assign w_commit = RegWriteW && !is_zero_reg(WriteRegW);

    regfile_2r1w #(
        .WIDTH (WIDTH)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (RegWriteW),
        .i_waddr  (WriteRegW),
        .i_wdata  (w_result),
        .i_raddr1 (A1),
        .i_raddr2 (A2),
        .o_rdata1 (RD1),
        .o_rdata2 (RD2)
    );

    // Writes to r0 still count as retired instructions but are not captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_count <= '0;
            r_last_reg     <= '0;
            r_last_data    <= '0;
        end else begin
            if (RegWriteW) begin
                r_retire_count <= r_retire_count + 1'b1;
            end
            if (w_commit) begin
                r_last_reg  <= WriteRegW;
                r_last_data <= w_result;
            end
        end
    end

    assign ResultW       = w_result;
    assign RetireCount   = r_retire_count;
    assign LastWriteReg  = r_last_reg;
    assign LastWriteData = r_last_data;

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: vector table, directed corner cases
// and randomized traffic against an array-based reference model.
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWriteW, MemtoRegW;
    logic [31:0] ALUOutW, ReadDataW;
    logic [4:0]  WriteRegW, A1, A2;
    logic [31:0] RD1, RD2, ResultW, LastWriteData;
    logic [31:0] RetireCount;
    logic [4:0]  LastWriteReg;

    logic [31:0] RD1_4, RD2_4, ResultW_4, LastWriteData_4;
    logic [3:0]  RetireCount_4;
    logic [4:0]  LastWriteReg_4;

    writeback_regfile #(.WIDTH(32), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .ALUOutW(ALUOutW), .ReadDataW(ReadDataW), .WriteRegW(WriteRegW),
        .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .ResultW(ResultW),
        .RetireCount(RetireCount), .LastWriteReg(LastWriteReg), .LastWriteData(LastWriteData)
    );

    writeback_regfile #(.WIDTH(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .ALUOutW(ALUOutW), .ReadDataW(ReadDataW), .WriteRegW(WriteRegW),
        .A1(A1), .A2(A2), .RD1(RD1_4), .RD2(RD2_4), .ResultW(ResultW_4),
        .RetireCount(RetireCount_4), .LastWriteReg(LastWriteReg_4), .LastWriteData(LastWriteData_4)
    );

    always #5 clk = ~clk;

    // Reference model: architectural state as plain arrays and counters.
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;
    logic [3:0]  m_cnt4;
    logic [4:0]  m_last_reg;
    logic [31:0] m_last_data;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        we;
        logic        m2r;
        logic [31:0] alu;
        logic [31:0] rdat;
        logic [4:0]  wr;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] exp_res;
        logic [31:0] exp_rd1;
        logic [31:0] exp_rd2;
        logic [31:0] exp_cnt;
        logic [4:0]  exp_last;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_result();
        return MemtoRegW ? ReadDataW : ALUOutW;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (RegWriteW && WriteRegW == a) return m_result();
        return m_regs[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_cnt = 32'd0;
        m_cnt4 = 4'd0;
        m_last_reg = 5'd0;
        m_last_data = 32'd0;
    endtask

    task automatic drive(input logic we, input logic m2r, input logic [31:0] alu,
                         input logic [31:0] rdat, input logic [4:0] wr,
                         input logic [4:0] a1, input logic [4:0] a2);
        RegWriteW = we; MemtoRegW = m2r; ALUOutW = alu; ReadDataW = rdat;
        WriteRegW = wr; A1 = a1; A2 = a2;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            if (RegWriteW) begin
                m_cnt  = m_cnt + 32'd1;
                m_cnt4 = m_cnt4 + 4'd1;
                if (WriteRegW != 5'd0) begin
                    m_regs[WriteRegW] = m_result();
                    m_last_reg  = WriteRegW;
                    m_last_data = m_result();
                end
            end
        end
        #1;
    endtask

    task automatic chk_comb(input string tag);
        chk({tag, ".ResultW"}, ResultW, m_result());
        chk({tag, ".RD1"}, RD1, m_read(A1));
        chk({tag, ".RD2"}, RD2, m_read(A2));
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".RetireCount"}, RetireCount, m_cnt);
        chk({tag, ".RetireCount4"}, {28'd0, RetireCount_4}, {28'd0, m_cnt4});
        chk({tag, ".LastWriteReg"}, {27'd0, LastWriteReg}, {27'd0, m_last_reg});
        chk({tag, ".LastWriteData"}, LastWriteData, m_last_data);
    endtask

    task automatic do_reset();
        @(negedge clk);
        RegWriteW = 1'b0;
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        logic [31:0] save_cnt, save_data;
        logic [4:0]  save_reg;

        rst_n = 1'b0;
        model_clear();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset.RD1", RD1, 32'd0);
        chk_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Vector table, applied from a freshly reset register file.
        vecs[0] = '{1'b1, 1'b0, 32'h100, 32'h200, 5'd1,  5'd1,  5'd2,  32'h100, 32'h100, 32'h0,   32'd1, 5'd1};
        vecs[1] = '{1'b1, 1'b1, 32'h101, 32'h201, 5'd2,  5'd1,  5'd2,  32'h201, 32'h100, 32'h201, 32'd2, 5'd2};
        vecs[2] = '{1'b0, 1'b0, 32'h102, 32'h202, 5'd1,  5'd1,  5'd2,  32'h102, 32'h100, 32'h201, 32'd2, 5'd2};
        vecs[3] = '{1'b1, 1'b0, 32'h103, 32'h0,   5'd0,  5'd0,  5'd1,  32'h103, 32'h0,   32'h100, 32'd3, 5'd2};
        vecs[4] = '{1'b1, 1'b0, 32'h104, 32'h0,   5'd31, 5'd31, 5'd31, 32'h104, 32'h104, 32'h104, 32'd4, 5'd31};
        vecs[5] = '{1'b0, 1'b1, 32'h0,   32'h205, 5'd31, 5'd31, 5'd2,  32'h205, 32'h104, 32'h201, 32'd4, 5'd31};
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].we, vecs[i].m2r, vecs[i].alu, vecs[i].rdat, vecs[i].wr, vecs[i].a1, vecs[i].a2);
            chk("vec.ResultW", ResultW, vecs[i].exp_res);
            chk("vec.RD1", RD1, vecs[i].exp_rd1);
            chk("vec.RD2", RD2, vecs[i].exp_rd2);
            step();
            chk("vec.RetireCount", RetireCount, vecs[i].exp_cnt);
            chk("vec.LastWriteReg", {27'd0, LastWriteReg}, {27'd0, vecs[i].exp_last});
            $display("vec %0d: we=%0b wr=%0d res=0x%08h rd1=0x%08h rd2=0x%08h cnt=%0d",
                     i, vecs[i].we, vecs[i].wr, ResultW, RD1, RD2, RetireCount);
        end

        // Result select: ALU then memory data into r7.
        drive(1'b1, 1'b0, 32'h11, 32'h22, 5'd7, 5'd7, 5'd0);
        chk("sel.alu", ResultW, 32'h11);
        step();
        drive(1'b1, 1'b1, 32'h11, 32'h22, 5'd7, 5'd7, 5'd0);
        chk("sel.mem", ResultW, 32'h22);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd0);
        chk("sel.r7", RD1, 32'h22);
        $display("seq result-select: r7=0x%08h", RD1);

        // Bypass on both ports, then architectural value after the edge.
        drive(1'b1, 1'b0, 32'hCAFE0001, 32'h0, 5'd9, 5'd9, 5'd9);
        chk("byp.RD1", RD1, 32'hCAFE0001);
        chk("byp.RD2", RD2, 32'hCAFE0001);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd9, 5'd9, 5'd9);
        chk("byp.post.RD1", RD1, 32'hCAFE0001);
        chk("byp.post.RD2", RD2, 32'hCAFE0001);
        $display("seq bypass: r9=0x%08h", RD1);

        // Write to r0 counts as retired but leaves r0 and last-write untouched.
        save_cnt = RetireCount; save_reg = LastWriteReg; save_data = LastWriteData;
        drive(1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd0, 5'd0);
        chk("r0.pre", RD1, 32'd0);
        step();
        chk("r0.post", RD1, 32'd0);
        chk("r0.cnt", RetireCount, save_cnt + 32'd1);
        chk("r0.lastreg", {27'd0, LastWriteReg}, {27'd0, save_reg});
        chk("r0.lastdata", LastWriteData, save_data);
        $display("seq r0-write: cnt=%0d last=%0d", RetireCount, LastWriteReg);

        // No-write cycles with a live-looking destination.
        drive(1'b1, 1'b0, 32'h77, 32'h0, 5'd3, 5'd3, 5'd0);
        step();
        save_cnt = RetireCount;
        drive(1'b0, 1'b0, 32'h55, 32'h0, 5'd3, 5'd3, 5'd3);
        repeat (4) step();
        chk("nowr.r3", RD1, 32'h77);
        chk("nowr.cnt", RetireCount, save_cnt);
        $display("seq no-write: r3=0x%08h cnt=%0d", RD1, RetireCount);

        // Undefined indices/data while idle must not disturb state.
        drive(1'b0, 1'bx, 32'hxxxxxxxx, 32'hxxxxxxxx, 5'bxxxxx, 5'd3, 5'd7);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd7);
        chk("xsafe.r3", RD1, 32'h77);
        chk("xsafe.r7", RD2, 32'h22);
        chk_state("xsafe");

        // Async reset mid-cycle with a write pending.
        drive(1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 5'd5, 5'd5, 5'd0);
        step();
        drive(1'b1, 1'b0, 32'h12345678, 32'h0, 5'd6, 5'd5, 5'd6);
        chk("rst.pre.r5", RD1, 32'hDEADBEEF);
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("rst.async.r5", RD1, 32'd0);
        chk_state("rst.async");
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd6);
        chk("rst.held.r5", RD1, 32'd0);
        chk("rst.held.r6", RD2, 32'd0);
        chk_state("rst.held");
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 32'hABCD0000, 32'h0, 5'd5, 5'd5, 5'd0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
        chk("rst.firstwr", RD1, 32'hABCD0000);
        chk_state("rst.firstwr");
        $display("seq async-reset: r5=0x%08h cnt=%0d", RD1, RetireCount);

        // Narrow counter wraps after 16 retires.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b0, $urandom, $urandom, 5'($urandom_range(0, 31)), 5'd0, 5'd0);
            step();
        end
        chk("wrap.cnt4", {28'd0, RetireCount_4}, 32'd1);
        chk("wrap.cnt32", RetireCount, 32'd17);
        $display("seq wrap: cnt4=%0d cnt32=%0d", RetireCount_4, RetireCount);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] wr;
            wr = 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 9) < 6), 1'($urandom), $urandom, $urandom, wr,
                  ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31)));
            chk_comb("rand");
            step();
            chk_state("rand");
        end
        $display("random phase: 400 cycles, cnt=%0d", RetireCount);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
